mem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage. It converts single-cycle load/store requests from the EX/MEM buffer into a request/acknowledge transaction with a variable-latency data memory. It drives `mem_stall` into the hazard unit for as long as a transaction is outstanding. It also raises `mem_alert` when the memory fails to respond within a bounded number of cycles.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_timeout_ctr.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
//   mem_state_t : controller FSM states (IDLE, BUSY, DONE)
//   MEM_ADDR_W  : default address width
//   MEM_DATA_W  : default data width
//   MEM_TIMEOUT : default number of BUSY cycles allowed before abandoning
//   ctr_width() : width of a counter able to hold 0..t
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic int ctr_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Timeout down-counter for the memory access controller.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (count forced to 0)
//   clr     : reload the counter with TIMEOUT-1 (start of a transaction)
//   en      : decrement by one (another BUSY cycle without ack)
//   expired : count has reached 0, i.e. the current BUSY cycle is the last
//             one allowed
// The count never wraps: it stops at zero, and the controller leaves BUSY
// in the cycle 'expired' is seen.
module mem_timeout_ctr
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CTR_W = ctr_width(TIMEOUT);
  localparam logic [CTR_W-1:0] LOAD_VAL = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with TIMEOUT-1 on entry, so zero is reached in the TIMEOUT-th
  // BUSY cycle.
  assign expired = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Turns single-cycle load/store requests into a req/ack transaction with a
// variable-latency memory, stalls the pipeline while the transaction is
// outstanding, and reports a memory that never answers.
// Pipeline side:
//   mem_rd, mem_wr      : load / store request (store wins if both high)
//   mem_addr, mem_wdata : access address and store data
//   mem_rdata           : registered load result (0 after a timeout)
//   mem_stall           : combinational stall to the hazard unit
//   mem_alert           : registered one-cycle timeout pulse
// Memory side:
//   dm_req, dm_we, dm_addr, dm_wdata : registered transaction request
//   dm_ack, dm_rdata                 : completion and read data
// Clocking: clk rising edge, rst_n asynchronous active-low.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              mem_alert,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata
);

  mem_state_t        state_q, state_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_alert_q, mem_alert_d;

  logic              ctr_clr;
  logic              ctr_en;
  logic              ctr_expired;
  logic              req_in;

  assign req_in = mem_rd | mem_wr;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    mem_rdata_d = mem_rdata_q;
    mem_alert_d = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_in) begin
          dm_addr_d  = mem_addr;
          dm_wdata_d = mem_wdata;
          dm_we_d    = mem_wr;
          dm_req_d   = 1'b1;
          ctr_clr    = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // An ack in the final allowed cycle still completes normally.
        if (dm_ack) begin
          if (!dm_we_q) begin
            mem_rdata_d = dm_rdata;
          end
          dm_req_d = 1'b0;
          state_d  = DONE;
        end else if (ctr_expired) begin
          dm_req_d    = 1'b0;
          mem_rdata_d = '0;
          mem_alert_d = 1'b1;
          state_d     = DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        // The request inputs still show the finished instruction here;
        // they must not start a second transaction.
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      mem_rdata_q <= '0;
      mem_alert_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      mem_alert_q <= mem_alert_d;
    end
  end

  // Stall already in the cycle a request first appears: the hazard unit
  // is combinational and the stage has to hold that instruction.
  assign mem_stall = ((state_q == IDLE) && req_in) || (state_q == BUSY);

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_alert = mem_alert_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_alert;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .mem_alert (mem_alert),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdin;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_alert;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic ack, input logic [31:0] rdin,
                     input logic e_req, input logic e_we, input logic [31:0] e_addr,
                     input logic [31:0] e_wdata, input logic e_stall,
                     input logic [31:0] e_rdata, input logic e_alert);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdin = rdin;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_alert = e_alert;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    dm_ack = 1'b0; dm_rdata = '0;

    //   rd wr addr   wdata   ack rdin        | req we e_addr e_wdata stall rdata      alert
    // Read, ack in BUSY cycle 3
    add(1,0,32'h100,32'h0,   0,32'h0,        0,0,32'h0,  32'h0,   1,32'h0,        0);
    add(1,0,32'h100,32'h0,   0,32'h0,        1,0,32'h100,32'h0,   1,32'h0,        0);
    add(1,0,32'h100,32'h0,   0,32'h0,        1,0,32'h100,32'h0,   1,32'h0,        0);
    add(1,0,32'h100,32'h0,   1,32'hDEADBEEF, 1,0,32'h100,32'h0,   1,32'h0,        0);
    add(1,0,32'h100,32'h0,   0,32'h0,        0,0,32'h100,32'h0,   0,32'hDEADBEEF, 0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,0,32'h100,32'h0,   0,32'hDEADBEEF, 0);
    // Zero-wait write; rdata bus garbage must not land in mem_rdata
    add(0,1,32'h20, 32'h55AA,0,32'h0,        0,0,32'h100,32'h0,   1,32'hDEADBEEF, 0);
    add(0,1,32'h20, 32'h55AA,1,32'h12345678, 1,1,32'h20, 32'h55AA,1,32'hDEADBEEF, 0);
    add(0,1,32'h20, 32'h55AA,0,32'h0,        0,1,32'h20, 32'h55AA,0,32'hDEADBEEF, 0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,1,32'h20, 32'h55AA,0,32'hDEADBEEF, 0);
    // Timeout (TIMEOUT=4), no ack, then a late ack in IDLE
    add(1,0,32'h40, 32'h0,   0,32'h0,        0,1,32'h20, 32'h55AA,1,32'hDEADBEEF, 0);
    add(1,0,32'h40, 32'h0,   0,32'h0,        1,0,32'h40, 32'h0,   1,32'hDEADBEEF, 0);
    add(1,0,32'h40, 32'h0,   0,32'h0,        1,0,32'h40, 32'h0,   1,32'hDEADBEEF, 0);
    add(1,0,32'h40, 32'h0,   0,32'h0,        1,0,32'h40, 32'h0,   1,32'hDEADBEEF, 0);
    add(1,0,32'h40, 32'h0,   0,32'h0,        1,0,32'h40, 32'h0,   1,32'hDEADBEEF, 0);
    add(1,0,32'h40, 32'h0,   0,32'h0,        0,0,32'h40, 32'h0,   0,32'h0,        1);
    add(0,0,32'h0,  32'h0,   1,32'h99999999, 0,0,32'h40, 32'h0,   0,32'h0,        0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,0,32'h40, 32'h0,   0,32'h0,        0);
    // Ack in the last allowed BUSY cycle (4): completes, no alert
    add(1,0,32'h44, 32'h0,   0,32'h0,        0,0,32'h40, 32'h0,   1,32'h0,        0);
    add(1,0,32'h44, 32'h0,   0,32'h0,        1,0,32'h44, 32'h0,   1,32'h0,        0);
    add(1,0,32'h44, 32'h0,   0,32'h0,        1,0,32'h44, 32'h0,   1,32'h0,        0);
    add(1,0,32'h44, 32'h0,   0,32'h0,        1,0,32'h44, 32'h0,   1,32'h0,        0);
    add(1,0,32'h44, 32'h0,   1,32'hCAFEF00D, 1,0,32'h44, 32'h0,   1,32'h0,        0);
    add(1,0,32'h44, 32'h0,   0,32'h0,        0,0,32'h44, 32'h0,   0,32'hCAFEF00D, 0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,0,32'h44, 32'h0,   0,32'hCAFEF00D, 0);
    // Back-to-back loads 0x10 then 0x14, no re-issue in DONE
    add(1,0,32'h10, 32'h0,   0,32'h0,        0,0,32'h44, 32'h0,   1,32'hCAFEF00D, 0);
    add(1,0,32'h10, 32'h0,   1,32'h11111111, 1,0,32'h10, 32'h0,   1,32'hCAFEF00D, 0);
    add(1,0,32'h10, 32'h0,   0,32'h0,        0,0,32'h10, 32'h0,   0,32'h11111111, 0);
    add(1,0,32'h14, 32'h0,   0,32'h0,        0,0,32'h10, 32'h0,   1,32'h11111111, 0);
    add(1,0,32'h14, 32'h0,   1,32'h22222222, 1,0,32'h14, 32'h0,   1,32'h11111111, 0);
    add(1,0,32'h14, 32'h0,   0,32'h0,        0,0,32'h14, 32'h0,   0,32'h22222222, 0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,0,32'h14, 32'h0,   0,32'h22222222, 0);
    // rd and wr both high: a write is issued
    add(1,1,32'h80, 32'hA5A5,0,32'h0,        0,0,32'h14, 32'h0,   1,32'h22222222, 0);
    add(1,1,32'h80, 32'hA5A5,1,32'h33333333, 1,1,32'h80, 32'hA5A5,1,32'h22222222, 0);
    add(1,1,32'h80, 32'hA5A5,0,32'h0,        0,1,32'h80, 32'hA5A5,0,32'h22222222, 0);
    add(0,0,32'h0,  32'h0,   0,32'h0,        0,1,32'h80, 32'hA5A5,0,32'h22222222, 0);

    // Reset values, while rst_n is held low
    #2;
    chk("reset dm_req",    32'(dm_req),    32'h0);
    chk("reset dm_we",     32'(dm_we),     32'h0);
    chk("reset dm_addr",   dm_addr,        32'h0);
    chk("reset dm_wdata",  dm_wdata,       32'h0);
    chk("reset mem_rdata", mem_rdata,      32'h0);
    chk("reset mem_alert", 32'(mem_alert), 32'h0);
    chk("reset mem_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      mem_rd = vecs[i].rd; mem_wr = vecs[i].wr; mem_addr = vecs[i].addr;
      mem_wdata = vecs[i].wdata; dm_ack = vecs[i].ack; dm_rdata = vecs[i].rdin;
      #3;
      chk($sformatf("row %0d dm_req", i),    32'(dm_req),    32'(vecs[i].e_req));
      chk($sformatf("row %0d dm_we", i),     32'(dm_we),     32'(vecs[i].e_we));
      chk($sformatf("row %0d dm_addr", i),   dm_addr,        vecs[i].e_addr);
      chk($sformatf("row %0d dm_wdata", i),  dm_wdata,       vecs[i].e_wdata);
      chk($sformatf("row %0d mem_stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
      chk($sformatf("row %0d mem_rdata", i), mem_rdata,      vecs[i].e_rdata);
      chk($sformatf("row %0d mem_alert", i), 32'(mem_alert), 32'(vecs[i].e_alert));
      $display("row %0d: rd=%0b wr=%0b addr=%h ack=%0b -> req=%0b we=%0b stall=%0b rdata=%h alert=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].ack,
               dm_req, dm_we, mem_stall, mem_rdata, mem_alert);
      next_cycle();
    end

    // Reset in the middle of a write transaction (BUSY cycle 2)
    mem_wr = 1'b1; mem_rd = 1'b0; mem_addr = 32'h60; mem_wdata = 32'h77; dm_ack = 1'b0;
    #3;
    chk("rst seq cycle0 stall", 32'(mem_stall), 32'h1);
    next_cycle();
    chk("rst seq cycle1 dm_req", 32'(dm_req), 32'h1);
    chk("rst seq cycle1 dm_we",  32'(dm_we),  32'h1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rst async dm_req",    32'(dm_req),    32'h0);
    chk("rst async dm_we",     32'(dm_we),     32'h0);
    chk("rst async mem_rdata", mem_rdata,      32'h0);
    chk("rst async mem_alert", 32'(mem_alert), 32'h0);
    mem_wr = 1'b0;
    next_cycle();
    dm_ack = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    #3;
    chk("rst release stall", 32'(mem_stall), 32'h0);
    next_cycle();
    chk("late ack ignored dm_req", 32'(dm_req), 32'h0);
    dm_ack = 1'b0; mem_rd = 1'b1; mem_addr = 32'h90;
    #3;
    chk("post-reset idle stall", 32'(mem_stall), 32'h1);
    next_cycle();
    chk("post-reset dm_req",  32'(dm_req), 32'h1);
    chk("post-reset dm_addr", dm_addr,     32'h90);
    dm_ack = 1'b1; dm_rdata = 32'h4444;
    next_cycle();
    dm_ack = 1'b0;
    #3;
    chk("post-reset rdata", mem_rdata,      32'h4444);
    chk("post-reset stall", 32'(mem_stall), 32'h0);
    $display("reset sequence: rdata=%h stall=%0b", mem_rdata, mem_stall);
    mem_rd = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
